// File: rtl/event_readout_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// event_readout_arbiter_if : valid/ready readout bus for timestamped records
// Rev 1.0
// ---------------------------------------------------------------------------
interface event_readout_arbiter_if #(
  parameter int DATA_W = 12
) ();
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface
`default_nettype wire

// File: rtl/event_readout_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// event_readout_arbiter : per-unit event capture, round-robin grant into a
// first-word fall-through FIFO of {unit_id, evt_code, timestamp} records
// Rev 1.0
// ---------------------------------------------------------------------------
module event_readout_arbiter #(
  parameter int NUM_UNITS  = 4,
  parameter int EVT_W      = 2,
  parameter int TS_W       = 8,
  parameter int FIFO_DEPTH = 8,
  localparam int ID_W  = $clog2(NUM_UNITS),
  localparam int PTR_W = $clog2(FIFO_DEPTH),
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1,
  localparam int REC_W = ID_W + EVT_W + TS_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_tick_i,
  input  logic [NUM_UNITS-1:0]       spike_i,
  input  logic [EVT_W*NUM_UNITS-1:0] event_i,
  event_readout_arbiter_if.master    rd_if,
  output logic [CNT_W-1:0]           fifo_count_o,
  output logic                       drop_sticky_o,
  input  logic                       clear_drop_i
);

  logic [TS_W-1:0]      ts_q;
  logic [NUM_UNITS-1:0] pend_q, pend_d, cap, grant_oh;
  logic [EVT_W-1:0]     pend_evt_q [NUM_UNITS];
  logic [TS_W-1:0]      pend_ts_q  [NUM_UNITS];
  logic [ID_W-1:0]      rr_ptr_q, grant_id, scan_idx;
  logic                 grant_vld, space, push, pop, drop, drop_q;
  logic [REC_W-1:0]     mem_q [FIFO_DEPTH];
  logic [REC_W-1:0]     push_rec, out_data_q;
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q, rd_nxt;
  logic [CNT_W-1:0]     count_q;

  assign pop    = (count_q != '0) & rd_if.ready;
  assign space  = (count_q < CNT_W'(FIFO_DEPTH)) | pop;
  assign rd_nxt = rd_ptr_q + PTR_W'(1);

  // First pending unit at or after rr_ptr, wrapping modulo NUM_UNITS.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      scan_idx = rr_ptr_q + ID_W'(k);
      if (!grant_vld && pend_q[scan_idx]) begin
        grant_vld = 1'b1;
        grant_id  = scan_idx;
      end
    end
  end

  assign push     = space & grant_vld;
  assign grant_oh = push ? (NUM_UNITS'(1) << grant_id) : '0;
  assign push_rec = {grant_id, pend_evt_q[grant_id], pend_ts_q[grant_id]};

  // A granted unit frees its slot this cycle, so a coincident spike is kept.
  always_comb begin
    pend_d = pend_q & ~grant_oh;
    cap    = '0;
    drop   = 1'b0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (spike_i[u]) begin
        if (!pend_q[u] || grant_oh[u]) begin
          pend_d[u] = 1'b1;
          cap[u]    = 1'b1;
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (cap[u]) begin
        pend_evt_q[u] <= event_i[u*EVT_W +: EVT_W];
        pend_ts_q[u]  <= ts_q;
      end
    end
    if (push) begin
      mem_q[wr_ptr_q] <= push_rec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q       <= '0;
      pend_q     <= '0;
      rr_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_q     <= 1'b0;
      out_data_q <= '0;
    end else begin
      if (sample_tick_i) begin
        ts_q <= ts_q + TS_W'(1);
      end
      pend_q <= pend_d;
      if (push) begin
        rr_ptr_q <= grant_id + ID_W'(1);
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_nxt;
      end
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      if (drop) begin
        drop_q <= 1'b1;
      end else if (clear_drop_i) begin
        drop_q <= 1'b0;
      end
      // Registered head: holds the last record while the FIFO is empty.
      if (count_q == '0) begin
        if (push) begin
          out_data_q <= push_rec;
        end
      end else if (pop) begin
        if (count_q > CNT_W'(1)) begin
          out_data_q <= mem_q[rd_nxt];
        end else if (push) begin
          out_data_q <= push_rec;
        end
      end
    end
  end

  assign rd_if.valid   = (count_q != '0);
  assign rd_if.data    = out_data_q;
  assign fifo_count_o  = count_q;
  assign drop_sticky_o = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_event_readout_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_event_readout_arbiter : directed bench for event_readout_arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_event_readout_arbiter;
  localparam int NUM_UNITS = 4;
  localparam int EVT_W     = 2;
  localparam int TS_W      = 8;
  localparam int DEPTH     = 8;
  localparam int CNT_W     = 4;
  localparam int REC_W     = 12;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       sample_tick;
  logic [NUM_UNITS-1:0]       spike;
  logic [EVT_W*NUM_UNITS-1:0] evt;
  logic [CNT_W-1:0]           fifo_count;
  logic                       drop_sticky;
  logic                       clear_drop;
  int                         checks = 0;
  int                         errors = 0;

  event_readout_arbiter_if #(.DATA_W(REC_W)) rd_if ();

  event_readout_arbiter #(
    .NUM_UNITS (NUM_UNITS),
    .EVT_W     (EVT_W),
    .TS_W      (TS_W),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_tick_i(sample_tick),
    .spike_i      (spike),
    .event_i      (evt),
    .rd_if        (rd_if.master),
    .fifo_count_o (fifo_count),
    .drop_sticky_o(drop_sticky),
    .clear_drop_i (clear_drop)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; sample_tick = 1'b0; spike = '0; evt = '0;
    clear_drop = 1'b0; rd_if.ready = 1'b0;
    step(2);
    rst = 1'b0;
    check("rst_valid", 32'(rd_if.valid), 32'd0);
    check("rst_data",  32'(rd_if.data),  32'd0);
    check("rst_count", 32'(fifo_count),  32'd0);
    check("rst_drop",  32'(drop_sticky), 32'd0);

    // Single event on unit 2 at ts=5
    sample_tick = 1'b1; step(5); sample_tick = 1'b0;
    spike = 4'b0100; evt = 8'h20; step(1); spike = '0;
    check("single_lat1_valid", 32'(rd_if.valid), 32'd0);
    step(1);
    check("single_valid", 32'(rd_if.valid), 32'd1);
    check("single_data",  32'(rd_if.data),  32'hA05);
    check("single_count", 32'(fifo_count),  32'd1);
    rd_if.ready = 1'b1; step(1); rd_if.ready = 1'b0;
    check("single_pop_valid", 32'(rd_if.valid), 32'd0);
    check("single_pop_count", 32'(fifo_count),  32'd0);
    check("empty_hold_data",  32'(rd_if.data),  32'hA05);

    rst = 1'b1; step(1); rst = 1'b0;
    check("rst2_data", 32'(rd_if.data), 32'd0);

    // All units together from rr_ptr=0: order 0,1,2,3
    rd_if.ready = 1'b1;
    spike = 4'hF; evt = 8'h1B; step(1); spike = '0;
    step(1); check("rr0_rec0", 32'(rd_if.data), 32'h300);
    step(1); check("rr0_rec1", 32'(rd_if.data), 32'h600);
    step(1); check("rr0_rec2", 32'(rd_if.data), 32'h900);
    step(1); check("rr0_rec3", 32'(rd_if.data), 32'hC00);
    check("rr0_rec3_count", 32'(fifo_count), 32'd1);
    step(1); check("rr0_drained", 32'(rd_if.valid), 32'd0);

    // Unit 1 alone moves rr_ptr to 2
    spike = 4'b0010; evt = 8'h04; step(1); spike = '0;
    step(1); check("u1_rec", 32'(rd_if.data), 32'h500);
    step(1); check("u1_drained", 32'(fifo_count), 32'd0);

    spike = 4'hF; evt = 8'h1B; step(1); spike = '0;
    step(1); check("rr2_rec0", 32'(rd_if.data), 32'h900);
    step(1); check("rr2_rec1", 32'(rd_if.data), 32'hC00);
    step(1); check("rr2_rec2", 32'(rd_if.data), 32'h300);
    step(1); check("rr2_rec3", 32'(rd_if.data), 32'h600);
    step(1); check("rr2_drained", 32'(rd_if.valid), 32'd0);

    // Fill under backpressure
    rd_if.ready = 1'b0;
    spike = 4'hF; evt = 8'h1B; step(1); spike = '0;
    step(5);
    check("fill_half", 32'(fifo_count), 32'd4);
    sample_tick = 1'b1; step(1); sample_tick = 1'b0;
    spike = 4'hF; step(1); spike = '0;
    step(5);
    check("full_count", 32'(fifo_count),  32'd8);
    check("full_valid", 32'(rd_if.valid), 32'd1);
    check("full_head",  32'(rd_if.data),  32'h900);
    sample_tick = 1'b1; step(1); sample_tick = 1'b0;
    spike = 4'hF; step(1); spike = '0;
    step(2);
    check("full_pending_count", 32'(fifo_count),  32'd8);
    check("full_pending_head",  32'(rd_if.data),  32'h900);
    check("no_drop_yet",        32'(drop_sticky), 32'd0);
    spike = 4'b0001; evt = 8'h00; step(1); spike = '0;
    check("drop_set", 32'(drop_sticky), 32'd1);
    spike = 4'b0001; clear_drop = 1'b1; step(1); spike = '0; clear_drop = 1'b0;
    check("drop_set_wins", 32'(drop_sticky), 32'd1);
    clear_drop = 1'b1; step(1); clear_drop = 1'b0;
    check("drop_cleared", 32'(drop_sticky), 32'd0);

    // Full FIFO, one pop plus one push in the same cycle
    rd_if.ready = 1'b1; step(1); rd_if.ready = 1'b0;
    check("full_pushpop_count", 32'(fifo_count), 32'd8);
    check("full_pushpop_head",  32'(rd_if.data), 32'hC00);

    // Reset mid-operation with records queued and units pending
    rst = 1'b1; step(1);
    check("midrst_valid", 32'(rd_if.valid), 32'd0);
    check("midrst_count", 32'(fifo_count),  32'd0);
    rst = 1'b0; step(3);
    check("postrst_valid", 32'(rd_if.valid), 32'd0);
    check("postrst_count", 32'(fifo_count),  32'd0);

    // Timestamp wrap
    sample_tick = 1'b1; step(256); sample_tick = 1'b0;
    spike = 4'b0010; evt = 8'h0C; step(1); spike = '0;
    step(1);
    check("wrap_valid", 32'(rd_if.valid), 32'd1);
    check("wrap_data",  32'(rd_if.data),  32'h700);
    rd_if.ready = 1'b1; step(1); rd_if.ready = 1'b0;
    check("wrap_drained", 32'(fifo_count), 32'd0);
    sample_tick = 1'b1; step(255);
    spike = 4'b0010; step(1); spike = '0; sample_tick = 1'b0;
    step(1);
    check("ts255_data", 32'(rd_if.data), 32'h7FF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
